// File: rtl/secded_scrubber_if.sv
// Memory-side port of the SECDED scrubber.
// The scrubber is the master and Data_Memory is the slave.
interface secded_scrubber_if #(
  parameter int ADDR_W = 6
);
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [38:0]       mem_rdata;
  logic [38:0]       mem_wdata;

  modport master (
    output mem_re,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_re,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/secded_scrubber.sv
// Background SECDED scrubber for Data_Memory.
// It reads, corrects and writes back words, yielding to the core.
module secded_scrubber #(
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int INTERVAL = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              i_scrub_en,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  secded_scrubber_if.master mem,
  output logic [CNT_W-1:0]  o_ce_count,
  output logic [CNT_W-1:0]  o_ue_count,
  output logic              o_ue_flag,
  output logic [ADDR_W-1:0] o_ue_addr,
  input  logic              i_ue_clear,
  output logic              o_pass_done
);

  localparam int WW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_ADVANCE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WW-1:0]     r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [38:0]       r_wdata;
  logic [CNT_W-1:0]  r_ce;
  logic [CNT_W-1:0]  r_ue;
  logic              r_ue_flag;
  logic [ADDR_W-1:0] r_ue_addr;

  logic [5:0]        w_syn;
  logic              w_par;
  logic [38:0]       w_fix;
  logic              w_ce;
  logic              w_ue;
  logic              w_re;
  logic              w_we;
  logic              w_hit;
  logic              w_last;

  assign w_hit  = i_core_we && (i_core_addr == r_addr);
  assign w_last = (r_addr == ADDR_W'(DEPTH - 1));

  // Syndrome/parity decode and single-bit correction of the read word
  always_comb begin
    w_syn = '0;
    for (int i = 1; i < 39; i++) begin
      if (mem.mem_rdata[i]) w_syn = w_syn ^ 6'(i);
    end
    w_par = ^mem.mem_rdata;
    w_fix = mem.mem_rdata;
    if (w_par) begin
      if (w_syn == 6'd0) begin
        w_fix[0] = ~w_fix[0];
      end else begin
        for (int i = 1; i < 39; i++) begin
          if (w_syn == 6'(i)) w_fix[i] = ~w_fix[i];
        end
      end
    end
    w_ce = w_par && (w_syn <= 6'd38);
    w_ue = (w_par && (w_syn > 6'd38)) ||
           (!w_par && (w_syn != 6'd0));
  end

  // Next state and strobes; strobes yield to the core and to reset
  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    w_we   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_scrub_en) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_scrub_en) begin
          w_next = S_IDLE;
        end else if (r_wcnt == WW'(INTERVAL - 1)) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        if (!i_core_req) begin
          w_re   = !rst_in;
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_ce && !w_ue && !w_hit) w_next = S_WRITE;
        else                         w_next = S_ADVANCE;
      end
      S_WRITE: begin
        if (w_hit) begin
          w_next = S_ADVANCE;
        end else if (!i_core_req) begin
          w_we   = !rst_in;
          w_next = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        w_next = i_scrub_en ? S_WAIT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Address, wait counter, write-back word and error log
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wcnt    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ce      <= '0;
      r_ue      <= '0;
      r_ue_flag <= 1'b0;
      r_ue_addr <= '0;
    end else begin
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
      if (r_state == S_ADVANCE) begin
        r_addr <= w_last ? '0 : r_addr + 1'b1;
      end
      if (r_state == S_CHECK && w_ce && !w_ue) begin
        r_wdata <= w_fix;
        if (r_ce != '1) r_ce <= r_ce + 1'b1;
      end
      if (i_ue_clear) begin
        r_ue_flag <= 1'b0;
        r_ue_addr <= '0;
      end
      if (r_state == S_CHECK && w_ue) begin
        if (r_ue != '1) r_ue <= r_ue + 1'b1;
        r_ue_flag <= 1'b1;
        if (!r_ue_flag || i_ue_clear) r_ue_addr <= r_addr;
      end
    end
  end

  assign mem.mem_re    = w_re;
  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign o_ce_count    = r_ce;
  assign o_ue_count    = r_ue;
  assign o_ue_flag     = r_ue_flag;
  assign o_ue_addr     = r_ue_addr;
  assign o_pass_done   = (r_state == S_ADVANCE) && w_last;

endmodule
